// File: rtl/fwd_hazard_unit_pkg.sv
// Shared encodings for the EX operand-mux selects and the in-flight destination records.
// The datapath mux instantiations reuse the FWD_* codes so both sides agree on the encoding.
package fwd_hazard_unit_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_WB1   = 2'b11;

  localparam int RA_W_DEFAULT = 5;
  localparam int REC_VALID_W  = 1;
  localparam int REC_MR_W     = 1;
  localparam int NUM_STAGES   = 4;
  localparam int NUM_SRCS     = 2;

  typedef enum logic [1:0] {
    STG_EX  = 2'd0,
    STG_MEM = 2'd1,
    STG_WB  = 2'd2,
    STG_WB1 = 2'd3
  } stage_e;

  // A record matches a source only when it is live and the register is not $0.
  function automatic logic src_hits(input logic use_src, input logic valid,
                                    input logic rd_nonzero, input logic rd_equal);
    return use_src & valid & rd_nonzero & rd_equal;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_sel_resolve.sv
// Resolves one source register against the EX, MEM and WB records, youngest producer first.
// Combinational; the top registers the result into EX alongside the instruction.
module fwd_sel_resolve
  import fwd_hazard_unit_pkg::*;
#(
  parameter int RA_W       = RA_W_DEFAULT,
  parameter bit WB1_BYPASS = 1'b1
) (
  input  logic [RA_W-1:0] src_i,
  input  logic            use_src_i,
  input  logic            ex_valid_i,
  input  logic [RA_W-1:0] ex_rd_i,
  input  logic            ex_mem_read_i,
  input  logic            mem_valid_i,
  input  logic [RA_W-1:0] mem_rd_i,
  input  logic            wb_valid_i,
  input  logic [RA_W-1:0] wb_rd_i,
  output logic [1:0]      sel_o,
  output logic            load_hit_o
);

  logic ex_m, mem_m, wb_m;

  assign ex_m  = src_hits(use_src_i, ex_valid_i,  |ex_rd_i,  ex_rd_i  == src_i);
  assign mem_m = src_hits(use_src_i, mem_valid_i, |mem_rd_i, mem_rd_i == src_i);
  assign wb_m  = src_hits(use_src_i, wb_valid_i,  |wb_rd_i,  wb_rd_i  == src_i);

  // A load in EX shadows older producers: the instruction bubbles and re-resolves later.
  always_comb begin
    sel_o      = FWD_RF;
    load_hit_o = 1'b0;
    if (ex_m) begin
      if (ex_mem_read_i) load_hit_o = 1'b1;
      else               sel_o      = FWD_EXMEM;
    end else if (mem_m) begin
      sel_o = FWD_MEMWB;
    end else if (wb_m && WB1_BYPASS) begin
      sel_o = FWD_WB1;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall unit beside the ID/EX register.
// Tracks destination records through EX, MEM, WB and the post-WB slot.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int RA_W       = RA_W_DEFAULT,
  parameter bit WB1_BYPASS = 1'b1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_flush,
  input  logic            hold,
  output logic            stall,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel
);

  logic [NUM_STAGES-1:0]            valid_q, valid_d;
  logic [NUM_STAGES-1:0][RA_W-1:0]  rd_q, rd_d;
  logic [NUM_STAGES-1:0]            mr_q, mr_d;
  logic [1:0]                       sel_a_q, sel_a_d;
  logic [1:0]                       sel_b_q, sel_b_d;

  logic [NUM_SRCS-1:0][RA_W-1:0]    src;
  logic [NUM_SRCS-1:0]              use_src;
  logic [NUM_SRCS-1:0][1:0]         sel_c;
  logic [NUM_SRCS-1:0]              load_hit;
  logic                             bubble;

  assign src     = {id_rt, id_rs};
  assign use_src = {id_use_rt, id_use_rs};

  for (genvar gi = 0; gi < NUM_SRCS; gi++) begin : g_src
    fwd_sel_resolve #(
      .RA_W       (RA_W),
      .WB1_BYPASS (WB1_BYPASS)
    ) u_resolve (
      .src_i         (src[gi]),
      .use_src_i     (use_src[gi]),
      .ex_valid_i    (valid_q[STG_EX]),
      .ex_rd_i       (rd_q[STG_EX]),
      .ex_mem_read_i (mr_q[STG_EX]),
      .mem_valid_i   (valid_q[STG_MEM]),
      .mem_rd_i      (rd_q[STG_MEM]),
      .wb_valid_i    (valid_q[STG_WB]),
      .wb_rd_i       (rd_q[STG_WB]),
      .sel_o         (sel_c[gi]),
      .load_hit_o    (load_hit[gi])
    );
  end

  assign stall  = (|load_hit) & ~id_flush & ~hold;
  assign bubble = stall | id_flush;

  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    mr_d    = mr_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    if (!hold) begin
      // Without the post-WB bypass the last slot is never populated.
      valid_d[STG_WB1] = WB1_BYPASS ? valid_q[STG_WB] : 1'b0;
      rd_d[STG_WB1]    = rd_q[STG_WB];
      mr_d[STG_WB1]    = mr_q[STG_WB];
      valid_d[STG_WB]  = valid_q[STG_MEM];
      rd_d[STG_WB]     = rd_q[STG_MEM];
      mr_d[STG_WB]     = mr_q[STG_MEM];
      valid_d[STG_MEM] = valid_q[STG_EX];
      rd_d[STG_MEM]    = rd_q[STG_EX];
      mr_d[STG_MEM]    = mr_q[STG_EX];
      valid_d[STG_EX]  = id_reg_write & ~bubble;
      rd_d[STG_EX]     = id_rd;
      mr_d[STG_EX]     = id_mem_read & ~bubble;
      sel_a_d          = bubble ? FWD_RF : sel_c[0];
      sel_b_d          = bubble ? FWD_RF : sel_c[1];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q <= '0;
      rd_q    <= '0;
      mr_q    <= '0;
      sel_a_q <= FWD_RF;
      sel_b_q <= FWD_RF;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      mr_q    <= mr_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign fwd_a_sel = sel_a_q;
  assign fwd_b_sel = sel_b_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: one task per scenario, expected codes worked out by hand.
// A second instance with the post-WB bypass disabled checks the 11-vs-00 difference.
module tb_fwd_hazard_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_use_rs, id_use_rt, id_reg_write, id_mem_read, id_flush, hold;
  logic       stall, stall0;
  logic [1:0] fwd_a_sel, fwd_b_sel, fwd_a_sel0, fwd_b_sel0;

  int checks = 0;
  int errors = 0;

  fwd_hazard_unit #(.RA_W(5), .WB1_BYPASS(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_flush(id_flush), .hold(hold), .stall(stall),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
  );

  fwd_hazard_unit #(.RA_W(5), .WB1_BYPASS(1'b0)) dut0 (
    .Clk(Clk), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_flush(id_flush), .hold(hold), .stall(stall0),
    .fwd_a_sel(fwd_a_sel0), .fwd_b_sel(fwd_b_sel0)
  );

  always #5 Clk = ~Clk;

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic [4:0] rd, input logic rw, input logic mr);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    id_flush = 1'b0; hold = 1'b0;
    #1;
  endtask

  task automatic nop();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    $display("t=%0t rs=%0d rt=%0d rd=%0d rw=%0b mr=%0b flush=%0b hold=%0b -> a=%b b=%b stall=%0b a0=%b b0=%b",
             $time, id_rs, id_rt, id_rd, id_reg_write, id_mem_read, id_flush, hold,
             fwd_a_sel, fwd_b_sel, stall, fwd_a_sel0, fwd_b_sel0);
  endtask

  task automatic flush_pipe();
    nop();
    repeat (4) step();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    nop();
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL reset_async_a got %b want 00", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL reset_async_b got %b want 00", fwd_b_sel); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    repeat (2) step();
    checks++; if (fwd_a_sel0 !== 2'b00) begin errors++; $display("FAIL reset_a_nobypass got %b want 00", fwd_a_sel0); end
    #2 Reset = 1'b0;
  endtask

  task automatic test_ex_forward();
    flush_pipe();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    step();
    set_id(5'd3, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ex_fwd_stall got %b want 0", stall); end
    step();
    checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL ex_fwd_a got %b want 01", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL ex_fwd_b got %b want 00", fwd_b_sel); end
  endtask

  task automatic test_mem_wb_forward();
    flush_pipe();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    step();
    nop();
    step();
    set_id(5'd1, 5'd3, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    step();
    checks++; if (fwd_b_sel !== 2'b10) begin errors++; $display("FAIL mem_fwd_b got %b want 10", fwd_b_sel); end
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL mem_fwd_a got %b want 00", fwd_a_sel); end
    checks++; if (fwd_b_sel0 !== 2'b10) begin errors++; $display("FAIL mem_fwd_b_nobypass got %b want 10", fwd_b_sel0); end
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    step();
    nop();
    step();
    step();
    set_id(5'd3, 5'd3, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0);
    step();
    checks++; if (fwd_a_sel !== 2'b11) begin errors++; $display("FAIL wb1_fwd_a got %b want 11", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL wb1_unused_rt got %b want 00", fwd_b_sel); end
    checks++; if (fwd_a_sel0 !== 2'b00) begin errors++; $display("FAIL wb1_a_nobypass got %b want 00", fwd_a_sel0); end
  endtask

  task automatic test_load_use();
    flush_pipe();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1);
    step();
    set_id(5'd4, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_use_stall got %b want 1", stall); end
    step();
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL load_use_bubble_a got %b want 00", fwd_a_sel); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_use_stall_once got %b want 0", stall); end
    step();
    checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL load_use_retry_a got %b want 10", fwd_a_sel); end
  endtask

  task automatic test_zero_and_flush();
    flush_pipe();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    step();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_reg_stall got %b want 0", stall); end
    step();
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL zero_reg_a got %b want 00", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL zero_reg_b got %b want 00", fwd_b_sel); end
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
    step();
    set_id(5'd5, 5'd0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0);
    id_flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flushed_reader_stall got %b want 0", stall); end
    step();
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL flushed_reader_a got %b want 00", fwd_a_sel); end
    set_id(5'd16, 5'd0, 1'b1, 1'b0, 5'd17, 1'b1, 1'b0);
    step();
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL flushed_not_producer got %b want 00", fwd_a_sel); end
  endtask

  task automatic test_youngest_wins();
    flush_pipe();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);
    step();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);
    step();
    set_id(5'd6, 5'd6, 1'b1, 1'b1, 5'd18, 1'b1, 1'b0);
    step();
    checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL youngest_a got %b want 01", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b01) begin errors++; $display("FAIL youngest_b got %b want 01", fwd_b_sel); end
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0);
    step();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0);
    id_flush = 1'b1;
    #1;
    step();
    set_id(5'd11, 5'd0, 1'b1, 1'b0, 5'd19, 1'b1, 1'b0);
    step();
    checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL mem_after_bubble_a got %b want 10", fwd_a_sel); end
  endtask

  task automatic test_hold_reset();
    flush_pipe();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0);
    step();
    set_id(5'd2, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
    step();
    checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL hold_pre_a got %b want 01", fwd_a_sel); end
    set_id(5'd4, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0);
    hold = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hold_stall got %b want 0", stall); end
    step();
    step();
    checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL hold_frozen_a got %b want 01", fwd_a_sel); end
    hold = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_release_stall got %b want 1", stall); end
    step();
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL hold_bubble_a got %b want 00", fwd_a_sel); end
    step();
    checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL hold_retry_a got %b want 10", fwd_a_sel); end
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    step();
    set_id(5'd7, 5'd7, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0);
    step();
    checks++; if (fwd_b_sel !== 2'b01) begin errors++; $display("FAIL pre_reset_b got %b want 01", fwd_b_sel); end
    #2 Reset = 1'b1;
    #1;
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL midreset_a got %b want 00", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL midreset_b got %b want 00", fwd_b_sel); end
    #1 Reset = 1'b0;
    step();
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL post_reset_a got %b want 00", fwd_a_sel); end
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_mem_wb_forward();
    test_load_use();
    test_zero_and_flush();
    test_youngest_wins();
    test_hold_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
